// File: rtl/ssb_sched_pkg.sv
// Shared types and constants for the SSB sideband-combiner scheduler.
// Sideband encodings, stage-1 operand record and channel-index width helper.
package ssb_sched_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int CH_W_MAX   = 3;

  localparam logic SB_USB = 1'b1;
  localparam logic SB_LSB = 1'b0;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
    logic                  mode;
    logic [CH_W_MAX-1:0]   ch;
    logic                  valid;
  } s1_rec_t;

endpackage

// File: rtl/ssb_demod_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward (mod NUM_CH) and
// advances the pointer past the granted channel on every grant.
module rr_arbiter
  import ssb_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CW     = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     grant_idx,
  output logic              grant_any
);

  logic [CW-1:0] ptr_q;
  logic [CW-1:0] ptr_d;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr_q) + i) % NUM_CH;
      if (enable && !grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = CW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

  // A grant is always taken (enable implies the downstream slot is free).
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = CW'((int'(grant_idx) + 1) % NUM_CH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ssb_demod_scheduler.sv
// Shares one (A +/- B) >>> 1 sideband combiner among NUM_CH channels through a
// round-robin arbiter and a 2-stage pipeline. Build option: SSB_ROUND_EN.
module ssb_demod_scheduler
  import ssb_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_a,
  input  logic [NUM_CH*DATA_W-1:0] in_b,
  input  logic [NUM_CH-1:0]        mode_usb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch
);

  logic [DATA_W-1:0] a_arr [NUM_CH];
  logic [DATA_W-1:0] b_arr [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign a_arr[gi] = in_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi] = in_b[gi*DATA_W +: DATA_W];
    end
  endgenerate

  s1_rec_t           s1_q;
  s1_rec_t           s1_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic [CH_W-1:0]   out_ch_q;
  logic [CH_W-1:0]   out_ch_d;

  logic              adv1;
  logic              adv2;
  logic              arb_en;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;

  assign adv2   = !out_valid_q || out_ready;
  assign adv1   = !s1_q.valid || adv2;
  assign arb_en = adv1 && !rst;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign in_ready = grant;

  always_comb begin
    s1_d = s1_q;
    if (adv1) begin
      s1_d.valid = grant_any;
      s1_d.a     = a_arr[grant_idx];
      s1_d.b     = b_arr[grant_idx];
      s1_d.mode  = mode_usb[grant_idx];
      s1_d.ch    = CH_W_MAX'(grant_idx);
    end
  end

  // One extra bit holds the full A +/- B range, so the halved value never overflows.
  logic [DATA_W:0]   a_x;
  logic [DATA_W:0]   b_x;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;

  always_comb begin
    a_x = {s1_q.a[DATA_W-1], s1_q.a};
    b_x = {s1_q.b[DATA_W-1], s1_q.b};
    sum = (s1_q.mode == SB_LSB) ? (a_x - b_x) : (a_x + b_x);
  end

`ifdef SSB_ROUND_EN
  logic [DATA_W+1:0] sum_r;
  logic [DATA_W:0]   rnd;

  // Round half up; only +2^(DATA_W-1) can escape the range and clamps to max.
  always_comb begin
    sum_r = {sum[DATA_W], sum} + (DATA_W+2)'(1);
    rnd   = sum_r[DATA_W+1:1];
    if (!rnd[DATA_W] && rnd[DATA_W-1]) begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      res = rnd[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    res = sum[DATA_W:1];
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (adv2) begin
      out_valid_d = s1_q.valid;
      out_data_d  = res;
      out_ch_d    = s1_q.ch[CH_W-1:0];
    end
  end

  logic ch_unused;
  assign ch_unused = ^s1_q.ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_ssb_demod_scheduler.sv
// Scoreboard bench for ssb_demod_scheduler: per-channel drivers push the
// hand-computed result at accept time, a monitor pops and compares outputs.
module tb_ssb_demod_scheduler;
  import ssb_sched_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DW     = 12;
  localparam int CW     = 2;
`ifdef SSB_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  wire  [NUM_CH-1:0]    in_valid;
  logic [NUM_CH-1:0]    in_ready;
  wire  [NUM_CH*DW-1:0] in_a;
  wire  [NUM_CH*DW-1:0] in_b;
  wire  [NUM_CH-1:0]    mode_usb;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_ch;

  always #5 clk = ~clk;

  ssb_demod_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mode_usb  (mode_usb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          mode;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
  } exp_t;

  vec_t vec_q [NUM_CH][$];
  exp_t exp_q [$];
  int   acc_ch [$];
  int   acc_cyc [$];
  int   out_cyc [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d (t=%0t)", name, got, req, $time);
    end
  endtask

  task automatic add(input int ch, input int a, input int b, input logic mode, input int e);
    vec_t v;
    v.a    = DW'(a);
    v.b    = DW'(b);
    v.mode = mode;
    v.exp  = DW'(e);
    vec_q[ch].push_back(v);
  endtask

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_drv
      logic          v;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          m;
      assign in_valid[gi]        = v;
      assign in_a[gi*DW +: DW]   = a;
      assign in_b[gi*DW +: DW]   = b;
      assign mode_usb[gi]        = m;

      initial begin
        vec_t cur;
        exp_t e;
        v = 1'b0; a = '0; b = '0; m = 1'b0;
        @(posedge clk); #1;
        forever begin
          if (vec_q[gi].size() == 0) begin
            v = 1'b0;
            @(posedge clk); #1;
          end else begin
            cur = vec_q[gi][0];
            v = 1'b1; a = cur.a; b = cur.b; m = cur.mode;
            @(negedge clk);
            if (in_ready[gi]) begin
              @(posedge clk);
              e.ch   = CW'(gi);
              e.data = cur.exp;
              exp_q.push_back(e);
              acc_ch.push_back(gi);
              acc_cyc.push_back(cyc);
              void'(vec_q[gi].pop_front());
              $display("accept ch=%0d a=%0d b=%0d usb=%0b", gi, $signed(cur.a), $signed(cur.b), cur.mode);
              #1;
            end else begin
              @(posedge clk); #1;
            end
          end
        end
      end
    end
  endgenerate

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_output", int'(out_ch), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("output ch=%0d data=%0d expected ch=%0d data=%0d", out_ch, $signed(out_data), e.ch, $signed(e.data));
        chk("sb_ch", int'(out_ch), int'(e.ch));
        chk("sb_data", int'($signed(out_data)), int'($signed(e.data)));
      end
    end
  end

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk); #1;
      done = (vec_q[0].size() == 0) && (vec_q[1].size() == 0) && (vec_q[2].size() == 0) &&
             (vec_q[3].size() == 0) && (exp_q.size() == 0) && !out_valid;
    end
    chk("drain_complete", int'(done), 1);
  endtask

  task automatic wait_acc(input int n);
    for (int k = 0; k < 50 && acc_ch.size() <= n; k++) begin
      @(posedge clk); #1;
    end
    chk("accept_seen", int'(acc_ch.size() > n), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int o0;
    int od;
    int oc;
    int exp_order [6];
    exp_order = '{0, 1, 2, 3, 0, 1};

    // reset state, with a request already pending on ch3
    add(3, 5, 5, SB_USB, 5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_ch", int'(out_ch), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle();

    // test 1: latency through both stages
    @(negedge clk);
    n0 = acc_ch.size();
    add(0, 100, 50, SB_USB, 75);
    wait_acc(n0);
    chk("t1_valid_after_accept", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("t1_valid_next_cycle", int'(out_valid), 1);
    chk("t1_out_data", int'($signed(out_data)), 75);
    chk("t1_out_ch", int'(out_ch), 0);
    wait_idle();

    // test 2: arithmetic corners on ch2
    @(negedge clk);
    add(2, 100, 50, SB_LSB, 25);
    add(2, -2048, -2048, SB_USB, -2048);
    add(2, -1, 0, SB_USB, RND ? 0 : -1);
    add(2, 2047, 2047, SB_USB, 2047);
    add(2, 2047, -2048, SB_LSB, 2047);
    add(2, -2048, 2047, SB_LSB, RND ? -2047 : -2048);
    add(2, 7, 4, SB_LSB, RND ? 2 : 1);
    add(2, -3, 0, SB_USB, RND ? -1 : -2);
    wait_idle();

    // test 3: all channels busy from a fresh pointer -> strict rotation, 1/cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n0 = acc_ch.size();
    o0 = out_cyc.size();
    add(0, 10, 20, SB_USB, 15);
    add(1, 10, 20, SB_LSB, -5);
    add(2, -100, -50, SB_USB, -75);
    add(3, -100, 50, SB_LSB, -75);
    add(0, 3, 3, SB_LSB, 0);
    add(1, 1, 2, SB_USB, RND ? 2 : 1);
    wait_idle();
    chk("t3_accept_count", acc_ch.size() - n0, 6);
    chk("t3_output_count", out_cyc.size() - o0, 6);
    if (acc_ch.size() - n0 == 6 && out_cyc.size() - o0 == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("t3_rotation", acc_ch[n0+i], exp_order[i]);
        chk("t3_accept_rate", acc_cyc[n0+i] - acc_cyc[n0], i);
        chk("t3_output_rate", out_cyc[o0+i] - out_cyc[o0], i);
      end
    end

    // test 4: backpressure for 5 cycles mid-stream
    @(negedge clk);
    add(0, 200, 100, SB_USB, 150);
    add(1, -400, 0, SB_USB, -200);
    add(2, 1000, 1000, SB_USB, 1000);
    add(3, 500, -100, SB_LSB, 300);
    add(0, 200, 100, SB_LSB, 50);
    add(1, 0, 400, SB_LSB, -200);
    add(2, -1000, 1000, SB_USB, 0);
    add(3, 12, -2, SB_USB, 5);
    repeat (3) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    od = int'(out_data);
    oc = int'(out_ch);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_data", int'(out_data), od);
      chk("t4_hold_ch", int'(out_ch), oc);
      chk("t4_in_ready_blocked", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    wait_idle();

    // test 5: mode flips right after the first accept on ch1
    @(negedge clk);
    add(1, 100, 50, SB_USB, 75);
    add(1, 100, 50, SB_LSB, 25);
    wait_idle();

    // test 6: reset with both stages full and requests pending
    out_ready = 1'b0;
    @(negedge clk);
    add(1, 10, 10, SB_USB, 10);
    add(1, 20, 20, SB_USB, 20);
    for (int k = 0; k < 50 && vec_q[1].size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("t6_fill_accepted", vec_q[1].size(), 0);
    @(negedge clk);
    add(1, 30, 10, SB_LSB, 10);
    add(2, 40, 40, SB_USB, 40);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t6_full_in_ready", int'(in_ready), 0);
    chk("t6_full_out_valid", int'(out_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("t6_post_rst_valid", int'(out_valid), 0);
    chk("t6_post_rst_data", int'(out_data), 0);
    chk("t6_post_rst_ch", int'(out_ch), 0);
    @(negedge clk);
    chk("t6_first_grant", int'(in_ready), 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
